// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier product path: default operand width,
// signed-digit encoding and the serializer FSM state type.
package mult_pkg;

  localparam int WL_DEF = 9;

  // Radix-2 signed digit encoding {neg,pos}; 2'b11 is never produced.
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_NEG  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage : mult_pkg

// File: rtl/prod_hold_reg.sv
// Single-entry valid/ready holding register. Accepts only when empty, so a
// push and a pop never coincide; the parked word is released on out_ready.
module prod_hold_reg #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full;
  logic [W-1:0] data;

  assign in_ready  = !full;
  assign out_valid = full;
  assign out_data  = data;

  // Fill on push, drain on pop; data captured only when a word is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

endmodule : prod_hold_reg

// File: rtl/mult_prod_sd_serializer.sv
// Serializes one 2*WL-bit two's-complement product per handshake into
// MSD-first radix-2 signed digits, one digit per accepted cycle. The first
// digit carries the negative sign weight, the rest are plain magnitude bits.
// Build option SER_SKID_EN adds a one-entry holding register so consecutive
// products stream with no idle cycle between them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no product loaded; out_valid=0, ready for a new product
// ST_SHIFT | presenting digit cnt of the loaded product; out_valid=1
module mult_prod_sd_serializer
  import mult_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*WL-1:0] in_prod,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_digit,
  output logic            out_first,
  output logic            out_last
);

  localparam int PW    = 2 * WL;
  localparam int CNT_W = $clog2(PW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PW - 1);

  ser_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]    sreg, sreg_nxt;

  logic          shifting;
  logic          dig_acc;
  logic          last_acc;
  logic          load_new;
  logic          load_hold;
  logic [PW-1:0] load_data;

  assign shifting = (state == ST_SHIFT);
  assign dig_acc  = shifting && out_ready;
  assign last_acc = dig_acc && (cnt == LAST);

`ifdef SER_SKID_EN
  logic          hold_full;
  logic          hold_in_valid;
  logic [PW-1:0] hold_data;

  // A product goes straight to the shift register when the register is free
  // (idle, or its last digit leaves this cycle); otherwise it parks in hold.
  assign load_new      = in_valid && in_ready && (!shifting || last_acc);
  assign load_hold     = last_acc && hold_full;
  assign hold_in_valid = in_valid && shifting && !last_acc;
  assign load_data     = load_hold ? hold_data : in_prod;

  prod_hold_reg #(
    .W (PW)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (hold_in_valid),
    .in_ready  (in_ready),
    .in_data   (in_prod),
    .out_valid (hold_full),
    .out_ready (load_hold),
    .out_data  (hold_data)
  );
`else
  assign in_ready  = !shifting;
  assign load_new  = in_valid && in_ready;
  assign load_hold = 1'b0;
  assign load_data = in_prod;
`endif

  // State, digit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Next state: load on accept, shift left on each accepted digit, reload or
  // drop to idle when the last digit is taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    unique case (state)
      ST_IDLE: begin
        if (load_new) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          sreg_nxt  = load_data;
        end
      end
      ST_SHIFT: begin
        if (dig_acc) begin
          if (cnt == LAST) begin
            cnt_nxt = '0;
            if (load_new || load_hold) begin
              sreg_nxt = load_data;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_nxt  = cnt + CNT_W'(1);
            sreg_nxt = {sreg[PW-2:0], 1'b0};
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The current digit's bit is always the shift register MSB; only the first
  // digit maps a set bit to -1 because it carries weight -2^(PW-1).
  always_comb begin
    out_valid = shifting;
    out_first = shifting && (cnt == '0);
    out_last  = shifting && (cnt == LAST);
    out_digit = SD_ZERO;
    if (shifting && sreg[PW-1]) begin
      out_digit = (cnt == '0) ? SD_NEG : SD_POS;
    end
  end

endmodule : mult_prod_sd_serializer

// File: tb/tb_mult_prod_sd_serializer.sv
// Directed and randomized bench for mult_prod_sd_serializer (WL=9, PW=18).
// Every accepted digit stream is rebuilt into a signed value and compared
// with the product accepted for it. Build with SER_SKID_EN to match a skid DUT.
module tb_mult_prod_sd_serializer;

  localparam int WL = 9;
  localparam int PW = 2 * WL;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prod   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_digit;
  logic          out_first;
  logic          out_last;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_prod_sd_serializer #(
    .WL (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_first (out_first),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream monitor: rebuilds each digit stream and matches it to the
  // product accepted for it, in acceptance order.
  int            idx      = 0;
  int            dv;
  longint        acc_sum  = 0;
  longint        last_sum = 0;
  bit            bad_dig  = 1'b0;
  int            streams  = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] p_exp;
  logic [1:0]    dig_log[PW];

  always @(negedge clk) begin
    if (!rst_n) begin
      idx     = 0;
      acc_sum = 0;
      bad_dig = 1'b0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        dig_log[idx] = out_digit;
        case (out_digit)
          2'b00:   dv = 0;
          2'b01:   dv = 1;
          2'b10:   dv = -1;
          default: begin dv = 0; bad_dig = 1'b1; end
        endcase
        chk("first_flag", 64'(out_first), 64'(idx == 0));
        chk("last_flag", 64'(out_last), 64'(idx == PW - 1));
        acc_sum += longint'(dv) <<< (PW - 1 - idx);
        if (idx == PW - 1) begin
          streams++;
          last_sum = acc_sum;
          chk("illegal_digit", 64'(bad_dig), 0);
          if (exp_q.size() == 0) begin
            chk("stream_has_product", 0, 1);
          end else begin
            p_exp = exp_q.pop_front();
            chk("digit_sum", acc_sum, longint'($signed(p_exp)));
          end
          idx     = 0;
          acc_sum = 0;
          bad_dig = 1'b0;
        end else begin
          idx++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_prod);
    end
  end

  // Offer a product and hold it until the serializer takes it.
  task automatic send(input logic [PW-1:0] p);
    int  n = 0;
    bit  taken;
    in_prod  = p;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!taken && n < 300);
    in_valid = 1'b0;
    if (!taken) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_valid || exp_q.size() != 0) && n < 500);
    if (n >= 500) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  bit     rand_on = 1'b0;
  int     vcnt, first_v, last_v, sent, busy_ready, s_before, n;
  bit     acc;
  logic [1:0] d_stall;

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_digit", 64'(out_digit), 0);
    chk("rst_out_first", 64'(out_first), 0);
    chk("rst_out_last", 64'(out_last), 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 1: -1 -> 10 followed by seventeen 01
    send(18'h3FFFF);
    wait_idle();
    chk("s1_d0", 64'(dig_log[0]), 2);
    chk("s1_d1", 64'(dig_log[1]), 1);
    chk("s1_d17", 64'(dig_log[17]), 1);
    chk("s1_sum", last_sum, -1);

    // 2: +65536 -> only d1 set, exactly PW valid cycles
    send(18'h10000);
    n = 0;
    vcnt = 0;
    do begin
      @(negedge clk);
      if (out_valid) vcnt++;
      n++;
    end while (out_valid && n < 100);
    chk("s2_valid_cycles", vcnt, 18);
    wait_idle();
    chk("s2_d0", 64'(dig_log[0]), 0);
    chk("s2_d1", 64'(dig_log[1]), 1);
    chk("s2_d2", 64'(dig_log[2]), 0);
    chk("s2_sum", last_sum, 65536);

    // 3: -131072 with a 3-cycle stall on d5
    send(18'h20000);
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(negedge clk);
    d_stall = out_digit;
    chk("s3_d5_value", 64'(out_digit), 0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk("s3_stall_valid", 64'(out_valid), 1);
      chk("s3_stall_digit", 64'(out_digit), 64'(d_stall));
      chk("s3_stall_first", 64'(out_first), 0);
      chk("s3_stall_last", 64'(out_last), 0);
      @(posedge clk);
      #1;
      if (c == 2) out_ready = 1'b1;
    end
    wait_idle();
    chk("s3_sum", last_sum, -131072);

    // 4: two products back-to-back with in_valid held high
    in_prod    = 18'h00123;
    in_valid   = 1'b1;
    sent       = 0;
    vcnt       = 0;
    first_v    = -1;
    last_v     = -1;
    busy_ready = 0;
    s_before   = streams;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
        last_v = c;
        if (in_ready) busy_ready++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent == 1) in_prod = 18'h3FF00;
        else in_valid = 1'b0;
      end
    end
    chk("s4_sent", sent, 2);
    chk("s4_streams", streams - s_before, 2);
    chk("s4_valid_cycles", vcnt, 36);
`ifdef SER_SKID_EN
    chk("s4_span_skid", last_v - first_v + 1, 36);
`else
    chk("s4_span_noskid", last_v - first_v + 1, 37);
    chk("s4_ready_while_busy", busy_ready, 0);
`endif
    chk("s4_sum_b", last_sum, -256);

    // 5: asynchronous reset in the middle of a stream
    send(18'h15555);
    repeat (9) begin @(posedge clk); #1; end
    s_before = streams;
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_valid", 64'(out_valid), 0);
    chk("s5_async_ready", 64'(in_ready), 1);
    chk("s5_async_digit", 64'(out_digit), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_no_stream", streams - s_before, 0);
    send(18'h0ABCD);
    wait_idle();
    chk("s5_streams", streams - s_before, 1);
    chk("s5_sum", last_sum, 43981);

    // 6: randomized products with random back-pressure
    s_before = streams;
    rand_on  = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(PW'($urandom));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    chk("s6_streams", streams - s_before, 1000);
    chk("s6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mult_prod_sd_serializer
